// File: rtl/alu_pkg.sv
// alu_pkg: aluOp field positions, funct3 codes and FSM state type for the execute-stage ALU.
package alu_pkg;
    localparam int ALU_EN = 4;
    localparam int ALT    = 3;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one bounded shift of data_i by amt_i (never more than SHIFT_STEP) left, logical right or arithmetic right.
module alu_shift_step #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             left_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] data_o
);
    logic signed [WIDTH-1:0] sra_v;
    // Kept separate so the arithmetic shift is evaluated in a signed context.
    assign sra_v  = $signed(data_i) >>> amt_i;
    assign data_o = left_i ? data_i << amt_i : arith_i ? sra_v : data_i >> amt_i;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake; single-cycle logic/arith/compare,
// iterative shifts of SHIFT_STEP bits per cycle.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int LW = $clog2(WIDTH);
    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, result_q, result_d, alu_res, shifted;
    logic [LW-1:0]    rem_q, rem_d, shamt, step;
    logic             left_q, left_d, arith_q, arith_d, zero_q;
    logic             accept, is_shift;
    logic [2:0]       f3;

    assign f3        = alu_op[2:0];
    assign shamt     = op_b[LW-1:0];
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign zero      = zero_q;
    assign accept    = in_valid && in_ready;
    assign is_shift  = alu_op[ALU_EN] && (f3 == F3_SLL || f3 == F3_SR);
    assign step      = (rem_q < LW'(SHIFT_STEP)) ? rem_q : LW'(SHIFT_STEP);

    // Shift ops land here only with shamt==0, where the result is op_a unchanged.
    assign alu_res = !alu_op[ALU_EN] ? op_b :
                     f3 == F3_ADD  ? (alu_op[ALT] ? op_a - op_b : op_a + op_b) :
                     f3 == F3_SLT  ? {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)} :
                     f3 == F3_SLTU ? {{(WIDTH-1){1'b0}}, op_a < op_b} :
                     f3 == F3_XOR  ? op_a ^ op_b :
                     f3 == F3_OR   ? op_a | op_b :
                     f3 == F3_AND  ? op_a & op_b : op_a;

    alu_shift_step #(.WIDTH(WIDTH), .AW(LW)) u_step (
        .data_i  (shreg_q),
        .amt_i   (step),
        .left_i  (left_q),
        .arith_i (arith_q),
        .data_o  (shifted)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        left_d   = left_q;
        arith_d  = arith_q;
        result_d = result_q;
        if (accept) begin
            if (is_shift && shamt != '0) begin
                state_d = SHIFT;
                shreg_d = op_a;
                rem_d   = shamt;
                left_d  = f3 == F3_SLL;
                arith_d = alu_op[ALT] && f3 == F3_SR;
            end else begin
                state_d  = DONE;
                result_d = alu_res;
            end
        end else if (state_q == SHIFT) begin
            shreg_d = shifted;
            rem_d   = rem_q - step;
            if (rem_q == step) begin
                state_d  = DONE;
                result_d = shifted;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            zero_q   <= result_d == '0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector self-checking bench for alu_exec_unit (WIDTH=32, SHIFT_STEP=1).
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    int          total = 0;
    int          bad   = 0;

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        #1 chk("in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n = 1;
        while (!out_valid && n < 100) begin
            chk({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_n);
    endtask

    initial begin
        logic [31:0] a, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(5'b10000, 32'd5, 32'd7);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add", result, 32'd12);
        chk("add_zero", {31'b0, zero}, 32'd0);
        issue(5'b11000, 32'd5, 32'd7);
        chk("sub", result, 32'hFFFF_FFFE);
        issue(5'b11000, 32'd9, 32'd9);
        chk("sub0", result, 32'd0);
        chk("sub0_zero", {31'b0, zero}, 32'd1);
        issue(5'b10010, 32'hFFFF_FFFF, 32'd1);
        chk("slt", result, 32'd1);
        issue(5'b10011, 32'hFFFF_FFFF, 32'd1);
        chk("sltu", result, 32'd0);
        chk("sltu_zero", {31'b0, zero}, 32'd1);
        issue(5'b11110, 32'h0000_F0F0, 32'h0000_0FF0);
        chk("or_alt", result, 32'h0000_FFF0);
        issue(5'b10111, 32'h0000_F0F0, 32'h0000_0FF0);
        chk("and", result, 32'h0000_00F0);
        issue(5'b01101, 32'h1111_1111, 32'hCAFE_0001);
        chk("pass", result, 32'hCAFE_0001);
        issue(5'b11101, 32'h8000_0000, 32'd4);
        wait_done("sra", 5);
        chk("sra", result, 32'hF800_0000);
        issue(5'b10101, 32'h8000_0000, 32'd4);
        wait_done("srl", 5);
        chk("srl", result, 32'h0800_0000);
        issue(5'b10001, 32'd1, 32'h25);
        wait_done("sll", 6);
        chk("sll", result, 32'h0000_0020);
        issue(5'b11101, 32'h4000_0000, 32'd2);
        wait_done("sra_pos", 3);
        chk("sra_pos", result, 32'h1000_0000);
        issue(5'b11001, 32'd3, 32'd1);
        wait_done("sll_alt", 2);
        chk("sll_alt", result, 32'd6);
        issue(5'b10001, 32'h0000_ABCD, 32'h20);
        wait_done("sh0", 1);
        chk("sh0", result, 32'h0000_ABCD);
        issue(5'b10100, 32'h0000_F0F0, 32'h0000_0FF0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 5'b10000;
        op_a      = 32'd1;
        op_b      = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0000_FF00);
        end
        out_ready = 1'b1;
        issue(5'b00000, 32'hDEAD_BEEF, 32'h0000_1234);
        chk("bp_pass", result, 32'h0000_1234);
        for (int i = 0; i < 8; i++) begin
            a = 32'h0F0F_0000 + i * 32'h0101;
            b = 32'h00FF_00F0 ^ (i << 4);
            issue(i[0] ? 5'b10111 : 5'b10110, a, b);
            chk("strm_valid", {31'b0, out_valid}, 32'd1);
            chk("strm", result, i[0] ? (a & b) : (a | b));
        end
        issue(5'b10001, 32'd1, 32'h14);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(5'b10000, 32'd3, 32'd4);
        chk("post_rst_add", result, 32'd7);
        @(negedge clk);
        chk("idle_valid", {31'b0, out_valid}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 5-bit aluOp produced by the ALU control decoder, plus operands A and B, and returns a registered result with a zero flag.
- Logical, arithmetic and compare ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, to keep the barrel shifter off the critical path.
- Valid/ready handshake on both input and output, so the pipeline can stall around multi-cycle shifts.

Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- SHIFT_STEP, 1, bits shifted per cycle in SHIFT state; power of two, at most WIDTH/2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_op  input  5  aluOp: [4] ALU enable, [3] funct7 alternate bit, [2:0] funct3
- op_a  input  WIDTH  operand A (rs1)
- op_b  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  ALU result
- zero  output  1  result == 0, registered alongside result

Behaviour:
- Reset values: state=IDLE, out_valid=0, result=0, zero=1, in_ready=1 (in_ready is combinational from state).
- Op semantics:
  - alu_op[4]=0: result = op_b (pass-through for load/store/jump address paths).
  - funct3=000: [3]=0 gives A+B, [3]=1 gives A-B, both modulo 2^WIDTH.
  - funct3=010 (slt): signed compare, result is 1 or 0.
  - funct3=011 (sltu): unsigned compare, result is 1 or 0.
  - funct3=100/110/111: xor/or/and.
  - funct3=001: sll.
  - funct3=101: [3]=0 gives srl, [3]=1 gives sra.
  - alu_op[3] is ignored for every op except add/sub and srl/sra.
- Shift amount: shamt = op_b[log2(WIDTH)-1:0]; upper bits of op_b are ignored.
- States:
  - IDLE: in_ready=1. On in_valid with a non-shift op, compute and register the result, go to DONE. On a shift op with shamt==0, register op_a, go to DONE. On a shift op with shamt>0, latch op_a into the shift register and shamt into the remaining count, go to SHIFT.
  - SHIFT: each cycle, shift by min(SHIFT_STEP, remaining) and subtract that from remaining. sra fills with the original sign bit, sll/srl fill with zeros. When remaining reaches 0 after the update, go to DONE.
  - DONE: out_valid=1; result and zero stay stable until out_ready. On out_ready, if in_valid is also high, accept the new op in the same cycle (in_ready = out_ready in DONE) and apply the IDLE accept rules; otherwise go to IDLE.
- Latency from accept to out_valid:
  - non-shift ops: 1 cycle;
  - shifts: 1 + ceil(shamt/SHIFT_STEP) cycles.
- Throughput: one non-shift op per cycle when out_ready is held high.
- in_ready=0 in SHIFT. The unit ignores op_a, op_b and alu_op whenever in_ready=0.
- Outputs must not glitch or change while out_valid=1 and out_ready=0.
- zero is computed on the final registered result, including pass-through and compare ops.
- Asynchronous reset in any state, including mid-SHIFT: return to IDLE immediately, drop out_valid, and discard the partial result.

Decomposition:
- alu_pkg holds:
  - localparams for the alu_op fields (ALU_EN bit index, ALT bit index, funct3 codes F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND);
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t.
- One combinational sub-module, alu_shift_step, performs a single bounded shift (data, amount up to SHIFT_STEP, direction, arithmetic flag). It is instantiated once inside alu_exec_unit.

Test Plan:
- Reset then add: alu_op=10000, A=5, B=7, in_valid pulse → next cycle out_valid=1, result=12, zero=0. Same with alu_op=11000 → result=0xFFFFFFFE; A=B=9 → result=0, zero=1.
- Compares: alu_op=10010, A=0xFFFFFFFF, B=1 → 1. Same operands with alu_op=10011 → 0.
- Shifts at SHIFT_STEP=1:
  - alu_op=11101, A=0x80000000, B=4 → out_valid 5 cycles after accept, result=0xF8000000, in_ready=0 throughout.
  - alu_op=10101 with the same operands → 0x08000000.
  - B=0x25 (shamt 5) with sll, A=1 → 0x20.
  - shamt=0 → result=A after 1 cycle.
- Backpressure and streaming: hold out_ready=0 for 3 cycles after an xor result → result stable and in_ready=0. Then assert out_ready together with in_valid (alu_op=00000, B=0x1234) → accepted in the same cycle, next result=0x1234.
- Stream 8 back-to-back or/and ops with out_ready=1 → 8 results on 8 consecutive cycles, in order, matching a reference model.
- Assert rst during cycle 3 of a 20-bit shift → out_valid=0, state IDLE, in_ready=1 immediately. A following add completes normally with a correct result.
